rvecc_scrub_ctrl: RTL and testbench

Background ECC scrubber for a 32-bit-data SECDED-protected SRAM. Each stored word is a 39-bit codeword: {ecc[6:0], data[31:0]}. ecc[5:0] are the Hamming check bits; ecc[6] is the overall parity of the 32 data bits and 6 check bits.
The block walks the array one address at a time at a programmable interval. Each step reads the codeword and recomputes the syndrome. A single-bit error is rewritten with corrected data and fresh ECC; a double-bit error is reported only. It sits beside the core's memory port and yields to functional traffic through a req/gnt handshake owned by the memory arbiter.

---
 rtl/rvecc_scrub_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_rvecc_scrub_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvecc_scrub_ctrl.sv
// Background SECDED scrubber for a 32-bit-data SRAM stored as {ecc[6:0], data[31:0]}.
// ecc[5:0] are Hamming check bits; check bit i covers every Hamming position with bit i set.
// Data bits sit at the non-power-of-two positions 3..38 in ascending order.
// ecc[6] is the even parity over data and ecc[5:0], so a good codeword XORs to 0.
//
// Memory handshake: mem_req is the valid and mem_gnt is the ready. A transfer happens
// on every cycle with mem_req && mem_gnt. While mem_req is high and mem_gnt is low,
// mem_we, mem_addr and mem_wdata do not change. Read data arrives on mem_rdata exactly
// one cycle after the read transfer.
module rvecc_scrub_ctrl #(
  parameter int ADDR_W = 10,
  parameter int INTV_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              scrub_en,
  input  logic [INTV_W-1:0] scrub_intv,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [38:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic [38:0]       mem_rdata,
  input  logic              func_wr,
  input  logic [ADDR_W-1:0] func_waddr,
  output logic              busy,
  output logic              sbe_pulse,
  output logic              dbe_pulse,
  output logic [ADDR_W-1:0] err_addr,
  output logic [CNT_W-1:0]  sbe_cnt,
  output logic [CNT_W-1:0]  dbe_cnt,
  output logic              pass_done,
  output logic [2:0]        dbg_state
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_RD   = 3'd2;
  localparam logic [2:0] S_RDAT = 3'd3;
  localparam logic [2:0] S_CHK  = 3'd4;
  localparam logic [2:0] S_WR   = 3'd5;
  localparam logic [2:0] S_NEXT = 3'd6;

  // Hamming check bits: XOR of the positions of all set data bits.
  function automatic logic [5:0] hamming_chk(input logic [31:0] d);
    logic [5:0] c;
    logic [5:0] k;
    c = '0;
    k = '0;
    for (int p = 1; p < 39; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (d[k[4:0]]) c = c ^ p[5:0];
        k = k + 6'd1;
      end
    end
    return c;
  endfunction

  // Flip the data bit at Hamming position syn; positions that hold no data bit leave d unchanged.
  function automatic logic [31:0] hamming_fix(input logic [31:0] d, input logic [5:0] syn);
    logic [31:0] r;
    logic [5:0]  k;
    r = d;
    k = '0;
    for (int p = 1; p < 39; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (p[5:0] == syn) r[k[4:0]] = ~d[k[4:0]];
        k = k + 6'd1;
      end
    end
    return r;
  endfunction

  logic [2:0]        state;
  logic [ADDR_W-1:0] addr;
  logic [INTV_W-1:0] intv_cnt;
  logic [38:0]       rd_q;
  logic [38:0]       wdata_q;
  logic              cancel;

  logic [5:0]  chk_c;
  logic [5:0]  syn;
  logic        par;
  logic        is_sbe;
  logic        is_dbe;
  logic [31:0] fixed;
  logic [5:0]  new_c;
  logic [38:0] new_cw;
  logic        func_hit;

  // Syndrome decode and re-encode of the captured codeword.
  always_comb begin
    chk_c    = hamming_chk(rd_q[31:0]);
    syn      = chk_c ^ rd_q[37:32];
    par      = ^rd_q;
    is_sbe   = par && (syn <= 6'd38);
    is_dbe   = par ? (syn > 6'd38) : (syn != 6'd0);
    fixed    = hamming_fix(rd_q[31:0], syn);
    new_c    = hamming_chk(fixed);
    new_cw   = {^{fixed, new_c}, new_c, fixed};
    func_hit = func_wr && (func_waddr == addr);
  end

  assign mem_req   = (state == S_RD) || (state == S_WR);
  assign mem_we    = (state == S_WR);
  assign mem_addr  = addr;
  assign mem_wdata = wdata_q;
  assign busy      = (state != S_IDLE) && (state != S_WAIT);
  assign pass_done = (state == S_NEXT) && (addr == {ADDR_W{1'b1}});
  assign dbg_state = state;

  // Step sequencer: interval wait, read, check, optional writeback, advance.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state    <= S_IDLE;
      addr     <= '0;
      intv_cnt <= '0;
      rd_q     <= '0;
      wdata_q  <= '0;
      cancel   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (scrub_en) begin
            intv_cnt <= scrub_intv;
            state    <= (scrub_intv == '0) ? S_RD : S_WAIT;
          end
        end
        S_WAIT: begin
          if (intv_cnt <= INTV_W'(1)) begin
            intv_cnt <= '0;
            state    <= S_RD;
          end else begin
            intv_cnt <= intv_cnt - INTV_W'(1);
          end
        end
        S_RD: begin
          // The race window opens on the read grant cycle itself.
          if (mem_gnt) begin
            cancel <= func_hit;
            state  <= S_RDAT;
          end
        end
        S_RDAT: begin
          rd_q <= mem_rdata;
          if (func_hit) cancel <= 1'b1;
          state <= S_CHK;
        end
        S_CHK: begin
          if (is_sbe) begin
            wdata_q <= new_cw;
            state   <= (cancel || func_hit) ? S_NEXT : S_WR;
          end else begin
            state <= S_NEXT;
          end
        end
        S_WR: begin
          // A colliding functional write makes our corrected data stale; abandon it.
          if (mem_gnt || func_hit) state <= S_NEXT;
        end
        S_NEXT: begin
          addr <= addr + ADDR_W'(1);
          if (scrub_en) begin
            intv_cnt <= scrub_intv;
            state    <= (scrub_intv == '0) ? S_RD : S_WAIT;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Error pulses, last error address and saturating counters, all updated from CHK.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      sbe_pulse <= 1'b0;
      dbe_pulse <= 1'b0;
      err_addr  <= '0;
      sbe_cnt   <= '0;
      dbe_cnt   <= '0;
    end else begin
      sbe_pulse <= (state == S_CHK) && is_sbe;
      dbe_pulse <= (state == S_CHK) && is_dbe;
      if (state == S_CHK && (is_sbe || is_dbe)) err_addr <= addr;
      if (state == S_CHK && is_sbe && sbe_cnt != {CNT_W{1'b1}}) sbe_cnt <= sbe_cnt + CNT_W'(1);
      if (state == S_CHK && is_dbe && dbe_cnt != {CNT_W{1'b1}}) dbe_cnt <= dbe_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_rvecc_scrub_ctrl.sv
// Directed bench for rvecc_scrub_ctrl: small array, narrow counters, behavioural SRAM.
module tb_rvecc_scrub_ctrl;

  localparam int ADDR_W = 4;
  localparam int INTV_W = 16;
  localparam int CNT_W  = 2;
  localparam int DEPTH  = 1 << ADDR_W;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd2;
  localparam logic [2:0] S_CHK  = 3'd4;
  localparam logic [2:0] S_NEXT = 3'd6;

  // Hand-derived codewords: data 1 sits at position 3 -> check 6'b000011, overall parity 1.
  localparam logic [38:0] CW_ONE     = {7'h43, 32'h0000_0001};
  localparam logic [38:0] CW_SBE_D2  = {7'h43, 32'h0000_0005};  // data bit 2 (position 6) flipped
  localparam logic [38:0] CW_SBE_P   = {7'h03, 32'h0000_0001};  // ecc[6] flipped
  localparam logic [38:0] CW_DBE     = {7'h00, 32'h0000_0003};  // data bits 0 and 1 flipped from zero

  logic              clk;
  logic              rst_l;
  logic              scrub_en;
  logic [INTV_W-1:0] scrub_intv;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [38:0]       mem_wdata;
  logic              mem_gnt;
  logic [38:0]       mem_rdata;
  logic              func_wr;
  logic [ADDR_W-1:0] func_waddr;
  logic              busy;
  logic              sbe_pulse;
  logic              dbe_pulse;
  logic [ADDR_W-1:0] err_addr;
  logic [CNT_W-1:0]  sbe_cnt;
  logic [CNT_W-1:0]  dbe_cnt;
  logic              pass_done;
  logic [2:0]        dbg_state;

  rvecc_scrub_ctrl #(.ADDR_W(ADDR_W), .INTV_W(INTV_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_l(rst_l), .scrub_en(scrub_en), .scrub_intv(scrub_intv),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rdata(mem_rdata), .func_wr(func_wr), .func_waddr(func_waddr),
    .busy(busy), .sbe_pulse(sbe_pulse), .dbe_pulse(dbe_pulse), .err_addr(err_addr),
    .sbe_cnt(sbe_cnt), .dbe_cnt(dbe_cnt), .pass_done(pass_done), .dbg_state(dbg_state)
  );

  // Clock and counters
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int sbe_seen = 0;
  int dbe_seen = 0;
  int pass_seen = 0;

  logic [38:0] mem [DEPTH];
  logic [ADDR_W+38:0] exp_q[$];
  logic [ADDR_W+38:0] obs_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic timeout_fail(input string tag);
    n_vec++;
    n_err++;
    $display("FAIL %s: wait bound expired at state %0d addr %0d", tag, dbg_state, mem_addr);
  endtask

  // Reference encoder: place data at non-power-of-two positions, then fold positions into check bits.
  function automatic logic [6:0] ref_ecc(input logic [31:0] d);
    logic [38:0] slot;
    logic [5:0]  c;
    int k;
    slot = '0;
    k = 0;
    for (int p = 3; p < 39; p++) begin
      if (p != 4 && p != 8 && p != 16 && p != 32) begin
        slot[p] = d[k];
        k++;
      end
    end
    for (int i = 0; i < 6; i++) begin
      c[i] = 1'b0;
      for (int p = 1; p < 39; p++) if (((p >> i) & 1) == 1) c[i] = c[i] ^ slot[p];
    end
    return {^{c, d}, c};
  endfunction

  // SRAM model: grants are transfers; read data one cycle after the read grant.
  always @(posedge clk) begin
    if (mem_req && mem_gnt) begin
      if (mem_we) begin
        mem[mem_addr] = mem_wdata;
        obs_q.push_back({mem_addr, mem_wdata});
      end else begin
        mem_rdata <= mem[mem_addr];
      end
    end
  end

  // Scoreboard: every granted write must match the next expected {addr, codeword}.
  always @(negedge clk) begin
    logic [ADDR_W+38:0] got;
    logic [ADDR_W+38:0] want;
    while (obs_q.size() > 0) begin
      got  = obs_q.pop_front();
      want = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      chk("wr_codeword", 64'(got), 64'(want));
    end
    if (sbe_pulse) sbe_seen++;
    if (dbe_pulse) dbe_seen++;
    if (pass_done) pass_seen++;
  end

  task automatic wait_read(input logic [ADDR_W-1:0] a);
    int n;
    n = 0;
    @(negedge clk);
    while (!(mem_req && !mem_we && mem_addr == a) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) timeout_fail("wait_read");
  endtask

  // Stimulus
  initial begin
    int n;
    int bad;
    int idle;
    rst_l = 1'b0; scrub_en = 1'b0; scrub_intv = '0; mem_gnt = 1'b1;
    func_wr = 1'b0; func_waddr = '0; mem_rdata = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    mem[0]  = {ref_ecc(32'h1234_5678), 32'h1234_5678};
    mem[5]  = CW_SBE_D2;
    mem[7]  = CW_SBE_P;
    mem[8]  = CW_DBE;
    mem[11] = CW_SBE_D2;
    mem[12] = CW_SBE_D2;
    mem[13] = CW_SBE_D2;
    exp_q.push_back({4'd5,  CW_ONE});
    exp_q.push_back({4'd7,  CW_ONE});
    exp_q.push_back({4'd12, CW_ONE});
    exp_q.push_back({4'd13, CW_ONE});

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_pulses", 64'({sbe_pulse, dbe_pulse, pass_done}), 64'd0);
    chk("rst_err_addr", 64'(err_addr), 64'd0);
    chk("rst_cnts", 64'({sbe_cnt, dbe_cnt}), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'(S_IDLE));
    rst_l = 1'b1;

    // Clean word at address 0: RD, RDAT, CHK, NEXT, then the next read.
    @(negedge clk);
    scrub_en = 1'b1;
    @(negedge clk);
    chk("first_rd_req", 64'({mem_req, mem_we, busy}), 64'b101);
    chk("first_rd_addr", 64'(mem_addr), 64'd0);
    repeat (4) @(negedge clk);
    chk("clean_latency", 64'({mem_req, mem_we, mem_addr}), 64'({1'b1, 1'b0, 4'd1}));
    chk("clean_no_pulse", 64'(sbe_seen + dbe_seen), 64'd0);

    // Data-bit SBE at 5.
    wait_read(4'd6);
    chk("sbe5_cnt", 64'(sbe_cnt), 64'd1);
    chk("sbe5_err_addr", 64'(err_addr), 64'd5);
    chk("sbe5_pulses", 64'(sbe_seen), 64'd1);

    // ecc[6] SBE at 7, DBE at 8.
    wait_read(4'd9);
    chk("dbe8_cnt", 64'(dbe_cnt), 64'd1);
    chk("dbe8_pulses", 64'(dbe_seen), 64'd1);
    chk("dbe8_err_addr", 64'(err_addr), 64'd8);
    chk("sbe7_cnt", 64'(sbe_cnt), 64'd2);

    // Stall the read of 9 for 10 cycles.
    mem_gnt = 1'b0;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (!(mem_req && !mem_we && mem_addr == 4'd9 && dbg_state == S_RD && busy)) bad++;
    end
    chk("stall_stable", 64'(bad), 64'd0);
    mem_gnt = 1'b1;

    // Functional write to 11 while its SBE is in CHK: no writeback.
    n = 0;
    @(negedge clk);
    while (!(dbg_state == S_CHK && mem_addr == 4'd11) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) timeout_fail("wait_chk11");
    func_wr = 1'b1;
    func_waddr = 4'd11;
    @(negedge clk);
    func_wr = 1'b0;
    chk("race_skip_wr", 64'(dbg_state), 64'(S_NEXT));
    chk("race_sbe_pulse", 64'(sbe_pulse), 64'd1);
    chk("race_sbe_cnt", 64'(sbe_cnt), 64'd3);

    // Two more SBEs: counter saturates at 3.
    wait_read(4'd14);
    chk("sat_pulses", 64'(sbe_seen), 64'd5);
    chk("sat_cnt", 64'(sbe_cnt), 64'd3);
    chk("sat_err_addr", 64'(err_addr), 64'd13);
    scrub_intv = 16'd3;

    // Wrap with a 3-cycle interval.
    n = 0;
    @(negedge clk);
    while (!pass_done && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) timeout_fail("wait_pass");
    idle = 0;
    n = 0;
    @(negedge clk);
    while (!mem_req && n < 50) begin
      if (!busy) idle++;
      @(negedge clk);
      n++;
    end
    if (n >= 50) timeout_fail("wait_wrap_rd");
    chk("intv_idle_cycles", 64'(idle), 64'd3);
    chk("wrap_addr", 64'(mem_addr), 64'd0);
    chk("pass_count", 64'(pass_seen), 64'd1);

    // Drop scrub_en mid-step: step finishes, then IDLE.
    scrub_en = 1'b0;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (mem_req) bad++;
    end
    chk("dis_no_req", 64'(bad), 64'd0);
    chk("dis_idle", 64'(dbg_state), 64'(S_IDLE));
    mem[3] = CW_SBE_D2;
    scrub_en = 1'b1;
    n = 0;
    @(negedge clk);
    while (!mem_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) timeout_fail("wait_resume");
    chk("resume_addr", 64'(mem_addr), 64'd1);

    // Reset during a pending write to 3.
    n = 0;
    @(negedge clk);
    while (!(mem_req && mem_we) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) timeout_fail("wait_wr3");
    mem_gnt = 1'b0;
    chk("wr3_addr", 64'(mem_addr), 64'd3);
    chk("wr3_wdata", 64'(mem_wdata), 64'(CW_ONE));
    @(negedge clk);
    #1 rst_l = 1'b0;
    #2;
    chk("rst_wr_req", 64'({mem_req, mem_we}), 64'd0);
    chk("rst_wr_data", 64'(mem_wdata), 64'd0);
    chk("rst_wr_cnts", 64'({sbe_cnt, dbe_cnt, err_addr}), 64'd0);
    chk("rst_wr_state", 64'({busy, dbg_state}), 64'd0);
    scrub_en = 1'b0;
    @(negedge clk);
    rst_l = 1'b1;
    mem_gnt = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (mem_req) bad++;
    end
    chk("post_rst_quiet", 64'(bad), 64'd0);
    chk("exp_writes_left", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
